apb_cfg_sequencer: RTL and testbench

//  APB master that replaces software/bench register programming of the TPU.

---
 rtl/apb_cfg_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_apb_cfg_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cfg_sequencer.sv
//==============================================================================
// Module      : apb_cfg_sequencer
// Description : Command-FIFO driven APB master (WRITE / READ / POLL-until-set).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef REG_ADDRWIDTH
`define REG_ADDRWIDTH 16
`endif
`ifndef REG_DATAWIDTH
`define REG_DATAWIDTH 32
`endif

module apb_cfg_sequencer #(
  parameter int ADDR_W   = `REG_ADDRWIDTH,
  parameter int DATA_W   = `REG_DATAWIDTH,
  parameter int DEPTH    = 8,
  parameter int POLL_MAX = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PC_W  = $clog2(POLL_MAX + 1);

  localparam logic [1:0] C_OP_WRITE = 2'b00;
  localparam logic [1:0] C_OP_READ  = 2'b01;
  localparam logic [1:0] C_OP_POLL  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_GAP    = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        op_mem   [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [PC_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic              err_q, err_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              w_empty, w_full, w_push, w_pop, w_flush, w_capture, w_active;
  logic [1:0]        w_head_op;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;

  assign w_empty     = (count_q == '0);
  assign w_full      = (count_q == CNT_W'(DEPTH));
  assign busy        = (state_q != S_IDLE);
  assign cmd_ready   = ~w_full & ~busy;
  assign w_push      = cmd_valid & cmd_ready;
  assign w_head_op   = op_mem[rd_ptr_q];
  assign w_head_addr = addr_mem[rd_ptr_q];
  assign w_head_data = data_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (w_push) begin
      op_mem[wr_ptr_q]   <= cmd_op;
      addr_mem[wr_ptr_q] <= cmd_addr;
      data_mem[wr_ptr_q] <= cmd_data;
    end
  end

  // Push and pop are mutually exclusive: pushes are only accepted while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (w_flush) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else if (w_push) begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      count_q  <= count_q + CNT_W'(1);
    end else if (w_pop) begin
      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q  <= count_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    poll_cnt_d = poll_cnt_q;
    err_d      = err_q;
    w_pop      = 1'b0;
    w_flush    = 1'b0;
    w_capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d      = 1'b0;
          poll_cnt_d = '0;
          state_d    = w_empty ? S_FIN : S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          state_d = S_GAP;
          if (w_head_op == C_OP_POLL) begin
            if ((PRDATA & w_head_data) != '0) begin
              w_pop      = 1'b1;
              poll_cnt_d = '0;
            end else if (poll_cnt_q == PC_W'(POLL_MAX - 1)) begin
              err_d      = 1'b1;
              w_flush    = 1'b1;
              poll_cnt_d = '0;
              state_d    = S_FIN;
            end else begin
              poll_cnt_d = poll_cnt_q + PC_W'(1);
            end
          end else begin
            w_pop     = 1'b1;
            w_capture = (w_head_op == C_OP_READ);
          end
        end
      end
      S_GAP:   state_d = w_empty ? S_FIN : S_SETUP;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      err_q      <= err_d;
      rd_valid_q <= w_capture;
      if (w_capture) rd_data_q <= PRDATA;
    end
  end

  // APB outputs decode straight from state so an async reset drops them at once.
  assign w_active = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign PSEL     = w_active;
  assign PENABLE  = (state_q == S_ACCESS);
  assign PADDR    = w_active ? w_head_addr : '0;
  assign PWRITE   = w_active && (w_head_op == C_OP_WRITE);
  assign PWDATA   = (w_active && (w_head_op == C_OP_WRITE)) ? w_head_data : '0;
  assign done     = (state_q == S_FIN);
  assign err      = err_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_cfg_sequencer.sv
//==============================================================================
// Module      : tb_apb_cfg_sequencer
// Description : Directed, table-driven bench for apb_cfg_sequencer with APB slave model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_apb_cfg_sequencer;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam logic [1:0] OP_W = 2'b00;
  localparam logic [1:0] OP_R = 2'b01;
  localparam logic [1:0] OP_P = 2'b10;
  localparam logic [AW-1:0] ENABLES = 8'h10;
  localparam logic [AW-1:0] STDN    = 8'h40;

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid, cmd_ready, start, busy, done, err, rd_valid;
  logic [1:0] cmd_op;
  logic [AW-1:0] cmd_addr, PADDR;
  logic [DW-1:0] cmd_data, rd_data, PWDATA, PRDATA;
  logic PWRITE, PSEL, PENABLE, PREADY;

  always #5 clk = ~clk;

  apb_cfg_sequencer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(8), .POLL_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .start(start), .busy(busy), .done(done), .err(err),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  // Slave model: register array, STDN register whose bit31 appears after stdn_fail reads.
  logic [DW-1:0] mem [0:255];
  int ws_req = 0, stdn_fail = 0, stdn_base = 0;
  int wait_cnt = 0, n_xfer = 0, n_stdn = 0, n_done = 0, n_rd = 0;
  logic [AW-1:0] log_addr [0:63];
  logic          log_wr   [0:63];
  logic [DW-1:0] log_wd   [0:63];
  logic [DW-1:0] rd_log   [0:63];

  assign PREADY = (wait_cnt >= ws_req);
  assign PRDATA = (PADDR == STDN) ? (((n_stdn - stdn_base) >= stdn_fail) ? 32'h8000_0000 : 32'h0)
                                  : mem[PADDR];

  always @(posedge clk) begin
    if (PSEL && PENABLE && !PREADY) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (PSEL && PENABLE && PREADY) begin
      if (n_xfer < 64) begin
        log_addr[n_xfer] <= PADDR;
        log_wr[n_xfer]   <= PWRITE;
        log_wd[n_xfer]   <= PWDATA;
      end
      n_xfer <= n_xfer + 1;
      if (PWRITE) mem[PADDR] <= PWDATA;
      if (!PWRITE && PADDR == STDN) n_stdn <= n_stdn + 1;
    end
    if (rd_valid) begin
      rd_log[n_rd % 64] <= rd_data;
      n_rd <= n_rd + 1;
    end
    if (done) n_done <= n_done + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output logic rdy);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    rdy = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Returns at the negedge of cycle T+1, where T is the cycle start was sampled in.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = -1;
    for (int k = 1; k <= maxc; k++) begin
      if (done) begin
        cyc = k;
        return;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_rdy;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t tbl [9];
  logic tr_psel [0:15], tr_pen [0:15], tr_pwr [0:15], tr_rv [0:15], tr_dn [0:15];
  logic [AW-1:0] tr_addr [0:15];

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic rdy;
    int cyc, xb, rb, db, r, n_acc;
    logic stable;

    tbl[0] = '{OP_W, 8'h20, 32'h1111_1111, 1'b1, 32'h0};
    tbl[1] = '{OP_W, 8'h21, 32'hA5A5_A5A5, 1'b1, 32'h0};
    tbl[2] = '{OP_R, 8'h20, 32'h0,         1'b1, 32'h1111_1111};
    tbl[3] = '{OP_W, 8'h22, 32'hDEAD_BEEF, 1'b1, 32'h0};
    tbl[4] = '{OP_R, 8'h21, 32'h0,         1'b1, 32'hA5A5_A5A5};
    tbl[5] = '{OP_R, 8'h22, 32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[6] = '{OP_W, 8'h20, 32'h0,         1'b1, 32'h0};
    tbl[7] = '{OP_R, 8'h20, 32'h0,         1'b1, 32'h0};
    tbl[8] = '{OP_W, 8'h23, 32'h1234_5678, 1'b0, 32'h0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; start = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_err_rv", {29'd0, done, err, rd_valid}, 32'd0);
    chk("rst_apb", {29'd0, PSEL, PENABLE, PWRITE}, 32'd0);
    chk("rst_paddr_pwdata", {24'd0, PADDR} | PWDATA, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write then read back ENABLES with a zero-wait slave.
    push(OP_W, ENABLES, 32'hF, rdy);
    push(OP_R, ENABLES, 32'h0, rdy);
    db = n_done;
    pulse_start();
    for (int k = 1; k <= 9; k++) begin
      tr_psel[k] = PSEL; tr_pen[k] = PENABLE; tr_pwr[k] = PWRITE;
      tr_rv[k] = rd_valid; tr_dn[k] = done; tr_addr[k] = PADDR;
      @(negedge clk);
    end
    chk("t1_setup_T1", {30'd0, tr_psel[1], tr_pen[1]}, 32'b10);
    chk("t1_setup_addr", 32'(tr_addr[1]), 32'(ENABLES));
    chk("t1_access_T2", {29'd0, tr_psel[2], tr_pen[2], tr_pwr[2]}, 32'b111);
    chk("t1_gap_T3", 32'(tr_psel[3]), 32'd0);
    chk("t1_read_access_T5", {29'd0, tr_psel[5], tr_pen[5], tr_pwr[5]}, 32'b110);
    chk("t1_rd_valid_T6", {30'd0, tr_rv[5], tr_rv[6]}, 32'b01);
    chk("t1_done_T7", {29'd0, tr_dn[6], tr_dn[7], tr_dn[8]}, 32'b010);
    chk("t1_rd_data", rd_data, 32'h0000_000F);
    chk("t1_done_count", 32'(n_done - db), 32'd1);
    chk("t1_idle", 32'(busy), 32'd0);

    // POLL succeeds on the fourth read.
    stdn_base = n_stdn; stdn_fail = 3;
    push(OP_P, STDN, 32'h8000_0000, rdy);
    xb = n_xfer; db = n_done;
    pulse_start();
    wait_done(40, cyc);
    chk("t2_done_cycle", 32'(cyc), 32'd13);
    chk("t2_reads", 32'(n_stdn - stdn_base), 32'd4);
    chk("t2_err", 32'(err), 32'd0);
    @(negedge clk);
    chk("t2_done_once", 32'(n_done - db), 32'd1);
    chk("t2_poll_is_read", {31'd0, log_wr[xb]} | log_wd[xb] | log_wd[xb+3], 32'd0);
    chk("t2_poll_addr", 32'(log_addr[xb+3]), 32'(STDN));

    // POLL timeout after POLL_MAX reads flushes the queued write.
    stdn_base = n_stdn; stdn_fail = 1000;
    push(OP_P, STDN, 32'h8000_0000, rdy);
    push(OP_W, 8'h30, 32'h55, rdy);
    xb = n_xfer;
    pulse_start();
    wait_done(60, cyc);
    chk("t3_done_cycle", 32'(cyc), 32'd12);
    chk("t3_reads", 32'(n_stdn - stdn_base), 32'd4);
    chk("t3_err_set", 32'(err), 32'd1);
    @(negedge clk);
    chk("t3_flushed_xfers", 32'(n_xfer - xb), 32'd4);
    chk("t3_err_sticky", 32'(err), 32'd1);
    pulse_start();
    chk("t3_empty_done", {29'd0, done, err, PSEL}, 32'b100);
    @(negedge clk);
    chk("t3_empty_no_xfer", 32'(n_xfer - xb), 32'd4);

    // Table: 9 pushes into an 8-deep FIFO, then execute.
    for (int i = 0; i < 9; i++) begin
      push(tbl[i].op, tbl[i].addr, tbl[i].data, rdy);
      chk($sformatf("t4_ready_%0d", i), 32'(rdy), 32'(tbl[i].exp_rdy));
    end
    chk("t4_full", 32'(cmd_ready), 32'd0);
    xb = n_xfer; rb = n_rd;
    pulse_start();
    wait_done(100, cyc);
    chk("t4_done_cycle", 32'(cyc), 32'd25);
    @(negedge clk);
    chk("t4_xfers", 32'(n_xfer - xb), 32'd8);
    r = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_addr_%0d", i), 32'(log_addr[xb+i]), 32'(tbl[i].addr));
      chk($sformatf("t4_pwrite_%0d", i), 32'(log_wr[xb+i]), 32'(tbl[i].op == OP_W));
      chk($sformatf("t4_pwdata_%0d", i), log_wd[xb+i], (tbl[i].op == OP_W) ? tbl[i].data : 32'h0);
      if (tbl[i].op == OP_R) begin
        chk($sformatf("t4_rd_%0d", i), rd_log[(rb + r) % 64], tbl[i].exp_rd);
        r++;
      end
    end
    chk("t4_rd_count", 32'(n_rd - rb), 32'd4);

    // Five wait states on a WRITE.
    ws_req = 5;
    push(OP_W, 8'h31, 32'hCAFE_F00D, rdy);
    pulse_start();
    @(negedge clk);
    n_acc = 0; stable = 1'b1;
    while (PENABLE && n_acc < 20) begin
      n_acc++;
      if (PADDR != 8'h31 || PWDATA != 32'hCAFE_F00D || !PSEL || !PWRITE) stable = 1'b0;
      @(negedge clk);
    end
    chk("t5_access_cycles", 32'(n_acc), 32'd6);
    chk("t5_stable", 32'(stable), 32'd1);
    wait_done(10, cyc);
    chk("t5_done_after_gap", 32'(cyc), 32'd2);
    @(negedge clk);
    chk("t5_mem", mem[8'h31], 32'hCAFE_F00D);
    ws_req = 0;

    // Asynchronous reset in the middle of a stalled ACCESS.
    ws_req = 100;
    push(OP_W, 8'h32, 32'h1, rdy);
    pulse_start();
    @(negedge clk); @(negedge clk);
    chk("t6_in_access", {30'd0, PSEL, PENABLE}, 32'b11);
    #2 reset = 1'b1;
    #1;
    chk("t6_apb_dropped", {29'd0, PSEL, PENABLE, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0; ws_req = 0;
    chk("t6_ready_after", 32'(cmd_ready), 32'd1);
    xb = n_xfer;
    pulse_start();
    chk("t6_fifo_empty_done", {30'd0, done, PSEL}, 32'b10);
    @(negedge clk); @(negedge clk);
    chk("t6_no_resume", 32'(n_xfer - xb), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
